bf16_dot_mac_stream: RTL
========================

BF16_DOT_MAC_STREAM -- requirements
Module: bf16_dot_mac_stream

Interface
REQ-001 SHALL have parameter LANES, default 2, bf16 pairs per input beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter CNT_W, default 8, width of the beat-count port.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin a dot product; sampled only in IDLE.
REQ-007 len  in  CNT_W  number of beats in the dot product; sampled with start.
REQ-008 bias  in  16  bf16 initial accumulator value; sampled with start.
REQ-009 clear  in  1  synchronous abort to IDLE.
REQ-010 in_valid  in  1  input beat valid.
REQ-011 in_ready  out  1  block accepts a beat.
REQ-012 in_a  in  16*LANES  bf16 operands; lane k is bits [16k+15:16k].
REQ-013 in_b  in  16*LANES  bf16 operands; same lane packing as in_a.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 out_data  out  16  bf16 result.
REQ-017 out_flags  out  3  {nan, inf, zero} of out_data.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 SHALL use the FSM states IDLE, ACCUM and DONE.
REQ-020 IDLE: in_ready=0, out_valid=0; on start=1, acc SHALL load normalised bias and len SHALL be latched into cnt.
REQ-021 IDLE with start=1 and len=0 SHALL go to DONE; with len!=0 it SHALL go to ACCUM.
REQ-022 ACCUM: in_ready=1; a beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-023 Each accepted beat SHALL update acc <= acc + S, where S is the sum of the lane products a_k*b_k.
REQ-024 S SHALL be reduced as a balanced pairwise tree in lane-index order, e.g. (p0+p1)+(p2+p3).
REQ-025 Each accepted beat SHALL decrement cnt; accepting a beat while cnt=1 SHALL go to DONE.
REQ-026 Cycles with in_valid=0 in ACCUM SHALL leave acc and cnt unchanged (gaps allowed).
REQ-027 DONE: out_valid=1; out_data=acc and out_flags SHALL be held stable until out_valid and out_ready are both 1, then the FSM SHALL go to IDLE.
REQ-028 Latency: out_valid SHALL rise on the cycle after the last beat is accepted, or the cycle after start when len=0.
REQ-029 start SHALL be ignored outside IDLE; len and bias SHALL be ignored except when start is accepted.
REQ-030 Priority SHALL be rst > clear > start/handshakes.
REQ-031 clear in any state SHALL go to IDLE next cycle with acc=0 and no out_valid pulse; a pending result is discarded.
REQ-032 Multiply and add SHALL follow bf16 rules with round-to-nearest-even on every multiply and add.
REQ-033 Denormal inputs and results SHALL be flushed to signed zero.
REQ-034 Overflow SHALL produce signed Inf.
REQ-035 Any NaN operand, Inf*0 or Inf-Inf SHALL produce canonical NaN 0x7FC0.
REQ-036 Sign of zero: the sum of +0 and -0 SHALL be +0.
REQ-037 out_flags SHALL decode from out_data: nan = exp all-ones with mantissa!=0; inf = exp all-ones with mantissa=0; zero = exp=0.

Reset
REQ-038 On rst=1 at a clock edge: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0x0000, out_flags=3'b001, busy=0.
REQ-039 rst mid-ACCUM or mid-DONE SHALL discard all progress with no out_valid pulse; operation SHALL resume from IDLE on the first cycle after rst falls.

Verification
REQ-040 LANES=2, bias=0x0000, len=1, a={0x4000,0x3F80}, b={0x4040,0x4000} -> out_data=0x4100 (8.0), flags 000, out_valid on the cycle after the beat.
REQ-041 len=3, bias=0x3F00, every beat lane0=1.0*1.0 and lane1=0*0, in_valid gaps of 2 cycles -> 0x4060 (3.5), exactly 3 beats accepted.
REQ-042 len=0, bias=0x4040 -> out_valid the cycle after start, out_data=0x4040, in_ready never high.
REQ-043 out_ready held low for 5 cycles in DONE -> out_data and out_flags stable, in_ready=0, a start pulse is ignored; IDLE the cycle after out_ready=1.
REQ-044 Special values: lane0 a=0x7F80, b=0x0000 -> 0x7FC0 with flags 100; a beat holding NaN 0x7FC1 -> 0x7FC0; products summing above max -> 0x7F80 with flags 010.
REQ-045 Abort: clear asserted after 2 of 4 beats -> IDLE the next cycle, no out_valid; the same sequence with rst instead gives identical behaviour plus the REQ-038 output values.

Source files
------------

// File: rtl/bf16_dot_mac_stream.sv
// Streaming bf16 dot-product accumulator: each accepted beat adds the pairwise-tree sum
// of LANES lane products into a bf16 accumulator; the result is held until consumed.
module bf16_dot_mac_stream #(
   parameter int LANES = 2,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_W-1:0]      len,
   input  logic [15:0]           bias,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*LANES-1:0]   in_a,
   input  logic [16*LANES-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           out_data,
   output logic [2:0]            out_flags,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [15:0] QNAN = 16'h7FC0;

   state_t             state, state_d;
   logic [15:0]        acc;
   logic [CNT_W-1:0]   cnt;
   logic [16*LANES-1:0] prod;
   logic [15:0]        beat_sum, acc_sum;
   logic               accept;

   // Round-to-nearest-even on a normalised significand, then saturate to Inf or flush to zero.
   function automatic logic [15:0] round_pack(input logic sign, input int exp_in,
                                              input logic [6:0] man, input logic guard,
                                              input logic sticky);
      logic [7:0] m8;
      int         e;
      m8 = {1'b0, man} + {7'h00, guard & (sticky | man[0])};
      e  = exp_in;
      if (m8[7]) e = e + 1;
      if (e >= 255) return {sign, 8'hFF, 7'h00};
      if (e <= 0)   return {sign, 15'h0000};
      return {sign, e[7:0], m8[6:0]};
   endfunction

   function automatic logic [15:0] bf16_canon(input logic [15:0] x);
      if (x[14:7] == 8'hFF && x[6:0] != 7'h00) return QNAN;
      if (x[14:7] == 8'h00) return {x[15], 15'h0000};
      return x;
   endfunction

   function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
      logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [15:0] p;
      int          e;
      s      = a[15] ^ b[15];
      a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_zero = (a[14:7] == 8'h00);
      b_zero = (b[14:7] == 8'h00);
      if (a_nan || b_nan) return QNAN;
      if (a_inf || b_inf) return (a_zero || b_zero) ? QNAN : {s, 8'hFF, 7'h00};
      if (a_zero || b_zero) return {s, 15'h0000};
      p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
      e = int'(a[14:7]) + int'(b[14:7]) - 127;
      if (p[15]) return round_pack(s, e + 1, p[14:8], p[7], |p[6:0]);
      return round_pack(s, e, p[13:7], p[6], |p[5:0]);
   endfunction

   // Operands aligned in a 19-bit frame: carry, hidden bit, 7 mantissa bits, 10 extra bits
   // with shifted-out bits folded into bit 0 as sticky.
   function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
      logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [15:0] big, sml;
      logic [18:0] fb, fs, al, sum, norm;
      logic        lost;
      int          diff, p;
      a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_zero = (a[14:7] == 8'h00);
      b_zero = (b[14:7] == 8'h00);
      if (a_nan || b_nan) return QNAN;
      if (a_inf && b_inf) return (a[15] == b[15]) ? a : QNAN;
      if (a_inf) return a;
      if (b_inf) return b;
      if (a_zero && b_zero) return {a[15] & b[15], 15'h0000};
      if (a_zero) return b;
      if (b_zero) return a;
      if (a[14:0] >= b[14:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      fb   = {2'b01, big[6:0], 10'h000};
      fs   = {2'b01, sml[6:0], 10'h000};
      diff = int'(big[14:7]) - int'(sml[14:7]);
      if (diff >= 19) begin
         al = 19'd1;
      end else begin
         al    = fs >> diff;
         lost  = |(fs & ((19'd1 << diff) - 19'd1));
         al[0] = al[0] | lost;
      end
      sum = (big[15] == sml[15]) ? fb + al : fb - al;
      if (sum == 19'd0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 19; i++) begin
         if (sum[i]) p = i;
      end
      norm = sum << (18 - p);
      return round_pack(big[15], int'(big[14:7]) + p - 17, norm[17:11], norm[10], |norm[9:0]);
   endfunction

   // Balanced reduction in lane order: leaves at LANES..2*LANES-1, root at node 1.
   function automatic logic [15:0] tree_sum(input logic [16*LANES-1:0] pv);
      logic [15:0] node [1:2*LANES-1];
      for (int k = 0; k < LANES; k++) node[LANES+k] = pv[16*k +: 16];
      for (int i = LANES - 1; i >= 1; i--) node[i] = bf16_add(node[2*i], node[2*i+1]);
      return node[1];
   endfunction

   always_comb begin
      prod = '0;
      for (int k = 0; k < LANES; k++) begin
         prod[16*k +: 16] = bf16_mul(in_a[16*k +: 16], in_b[16*k +: 16]);
      end
      beat_sum = tree_sum(prod);
      acc_sum  = bf16_add(acc, beat_sum);
   end

   assign accept = (state == ACCUM) && in_valid && !clear;

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_d = (len == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = !clear;
            if (in_valid && cnt == CNT_W'(1)) state_d = DONE;
         end
         DONE: begin
            out_valid = !clear;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= 16'h0000;
         cnt   <= '0;
      end else begin
         state <= state_d;
         if (clear) begin
            acc <= 16'h0000;
            cnt <= '0;
         end else if (state == IDLE && start) begin
            acc <= bf16_canon(bias);
            cnt <= len;
         end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign out_data  = acc;
   assign out_flags = {(acc[14:7] == 8'hFF) && (acc[6:0] != 7'h00),
                       (acc[14:7] == 8'hFF) && (acc[6:0] == 7'h00),
                       (acc[14:7] == 8'h00)};
   assign busy      = (state != IDLE);

endmodule
